step_pulse_gen: RTL

// Upstream of the SoC single-step clock: turns the raw board push-button into a clean,
// one-cycle step enable on the fast board clock. Synchronises, debounces, edge-detects
// and optionally auto-repeats while held, so the core can be stepped by hand or run slowly.

---
 rtl/step_pulse_gen.sv | 115 +++++++++++
 1 files changed

// File: rtl/step_pulse_gen.sv
// Push-button to single-cycle step enable: 2-FF synchroniser, counter debounce,
// press edge detection and optional auto-repeat while the button is held.
module step_pulse_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        button,
  input  logic        repeat_en,
  output logic        step,
  output logic        btn_state,
  output logic [15:0] step_count
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT
  } state_t;

  state_t           state;
  logic             sync_ff;
  logic             btn_sync;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] rpt_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff  <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      sync_ff  <= button;
      btn_sync <= sync_ff;
    end
  end

  // Any sample agreeing with the current level restarts the stability count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_state <= 1'b0;
      deb_cnt   <= '0;
    end else if (btn_sync == btn_state) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      btn_state <= ~btn_state;
      deb_cnt   <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      rpt_cnt    <= '0;
      step       <= 1'b0;
      step_count <= '0;
    end else begin
      step <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (btn_state) begin
            step       <= 1'b1;
            step_count <= step_count + 16'd1;
            rpt_cnt    <= '0;
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!btn_state) begin
            rpt_cnt <= '0;
            state   <= ST_IDLE;
          end else if (!repeat_en) begin
            rpt_cnt <= '0;
          end else if (rpt_cnt == DLY_LAST) begin
            step       <= 1'b1;
            step_count <= step_count + 16'd1;
            rpt_cnt    <= '0;
            state      <= ST_REPEAT;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
        end
        ST_REPEAT: begin
          // Release is tested first so it wins over a simultaneous period expiry.
          if (!btn_state) begin
            rpt_cnt <= '0;
            state   <= ST_IDLE;
          end else if (!repeat_en) begin
            rpt_cnt <= '0;
            state   <= ST_HOLD;
          end else if (rpt_cnt == PER_LAST) begin
            step       <= 1'b1;
            step_count <= step_count + 16'd1;
            rpt_cnt    <= '0;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
        end
        default: begin
          rpt_cnt <= '0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
